crono_ctrl: RTL and testbench
=============================

# crono_ctrl

Run-time controller for the chronometer/countdown function. It takes the BCD HH:MM:SS value prepared by the setting editor and owns the editor's enable. On start it loads that value and counts it down once per 1 Hz tick, with pause, resume and cancel. It raises an alarm on reaching 00:00:00. It sits between the button debouncers, the 1 Hz divider, the setting editor and the display multiplexer.

## Interface
- ALARM_SECS, default 10: number of ticks the alarm stays active in DONE before automatic return to EDIT; range 1..255.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- tick  in  1  one-cycle pulse at 1 Hz, synchronous to clk.
- mode_en  in  1  timer mode selected on the display; gates button handling and edit_en.
- BTstart  in  1  debounced level; rising edge is start/resume.
- BTstop  in  1  debounced level; rising edge is pause/cancel/acknowledge.
- HCin, MCin, SCin  in  8 each  BCD hours/minutes/seconds from the editor.
- edit_en  out  1  enable for the editor; combinational: mode_en && state==EDIT.
- HCout, MCout, SCout  out  8 each  BCD remaining time.
- alarm  out  1  alarm drive.
- state  out  2  EDIT=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Button edges:
  - Each button has a reference register that copies the level every cycle.
  - An edge is level=1 and ref=0, qualified by mode_en.
  - The ref registers update regardless of mode_en, so edges that occur while mode_en is low are discarded, not deferred.
- EDIT:
  - Outputs hold 00:00:00 and alarm=0.
  - A start edge with valid, non-zero inputs loads HCin/MCin/SCin into the outputs and moves to RUN.
  - Inputs are valid when HH<=0x23, minute/second tens<=5 and every units digit<=9.
  - A start edge with zero or invalid inputs is ignored; the block stays in EDIT.
- RUN:
  - Each tick applies a BCD decrement with borrow chain s-units → s-tens → m-units → m-tens → h-units → h-tens.
  - An underflowing units digit wraps 0→9. A minutes/seconds tens digit wraps 0→5. Hours have no wrap beyond 00.
  - A decrement that produces 00:00:00 enters DONE on the same edge, with alarm=1.
  - A stop edge moves to PAUSE.
- PAUSE:
  - Count frozen; ticks are ignored.
  - A start edge returns to RUN.
  - A stop edge clears the outputs to 00:00:00 and moves to EDIT.
- DONE:
  - Outputs hold 00:00:00.
  - An internal 8-bit tick counter counts ALARM_SECS ticks; reaching the limit returns to EDIT with alarm=0.
  - A start or stop edge returns to EDIT immediately.
- mode_en low:
  - Counting continues in RUN and the alarm continues in DONE.
  - Only the button edges and edit_en are suppressed.
- Simultaneous events:
  - Start and stop edges in the same cycle: stop wins, start is dropped.
  - Tick and stop edge in the same RUN cycle: the decrement is applied and the state goes to PAUSE. If that decrement reaches zero, DONE wins.

## Timing
- All outputs are registered, except edit_en.
- Reset values:
  - state=EDIT (0).
  - HCout=MCout=SCout=8'h00.
  - alarm=0.
  - Button refs=0 and alarm counter=0.
- Button latency: the state changes at the first posedge where the level is sampled 1 and the ref is 0, i.e. the edge at which the press is first seen.
- Tick latency: the decremented value appears at the posedge that samples tick=1.
- Reset asserted mid-count aborts immediately; no partial value is retained.
- A button held high gives exactly one edge; it must go low for at least one cycle before it can re-trigger.

## Configuration
- CRONO_BLINK_EN defined: in DONE, alarm starts at 1 on entry and toggles on every tick, giving a 0.5 Hz blink.
- CRONO_BLINK_EN undefined: alarm is steady 1 for the whole DONE period.
- In both builds, alarm is 0 in every state other than DONE.

## Test plan
- Reset, then HCin/MCin/SCin=00:00:03, start edge, 3 ticks → outputs 02, 01, 00; state=3 and alarm=1 on the third tick.
- Load 01:00:00, one tick → 00:59:59; load 10:00:00, one tick → 09:59:59.
- RUN at 00:00:10: stop edge → PAUSE, 2 ticks leave 00:00:10; start edge → RUN; second stop edge from PAUSE → EDIT, outputs 00:00:00.
- Start with inputs 24:00:00, 00:60:00 or 00:00:00 → state stays 0, outputs stay 00:00:00.
- DONE with ALARM_SECS=10 and no buttons → EDIT after the 10th tick. With CRONO_BLINK_EN: alarm 1,0,1,… on successive ticks. Stop edge after 2 ticks → EDIT, alarm=0.
- Start and stop rising in the same cycle in EDIT → stays EDIT. mode_en=0 with a start edge → ignored. reset low mid-RUN → all outputs 0 asynchronously.

Source files
------------

// File: rtl/crono_ctrl.sv
// Countdown run-time controller: loads the edited HH:MM:SS, decrements once per tick, alarms at zero.
// Optional build macro CRONO_BLINK_EN: alarm blinks in DONE, toggling on every tick, instead of holding steady.
//
// state | meaning
// EDIT  | editor owns the setting, outputs 00:00:00
// RUN   | counting down on tick
// PAUSE | count frozen, waiting for resume or cancel
// DONE  | reached zero, alarm active for ALARM_SECS ticks
module crono_ctrl #(
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode_en,
  input  logic       BTstart,
  input  logic       BTstop,
  input  logic [7:0] HCin,
  input  logic [7:0] MCin,
  input  logic [7:0] SCin,
  output logic       edit_en,
  output logic [7:0] HCout,
  output logic [7:0] MCout,
  output logic [7:0] SCout,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } st_t;

  localparam logic [7:0] ALARM_LIM = ALARM_SECS[7:0];

  st_t        st;
  logic       start_ref, stop_ref;
  logic [7:0] alarm_cnt;
  logic       start_edge, stop_edge, start_go, stop_go;
  logic       in_ok, in_nz;
  logic [23:0] dec_val;

  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    r = v;
    if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
        else begin
          r[11:8] = 4'd9;
          if (v[15:12] != 4'd0) r[15:12] = v[15:12] - 4'd1;
          else begin
            r[15:12] = 4'd5;
            if (v[19:16] != 4'd0) r[19:16] = v[19:16] - 4'd1;
            else begin
              r[19:16] = 4'd9;
              if (v[23:20] != 4'd0) r[23:20] = v[23:20] - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // Refs track the level even with mode_en low, so edges seen then are dropped.
  assign start_edge = mode_en & BTstart & ~start_ref;
  assign stop_edge  = mode_en & BTstop & ~stop_ref;
  assign stop_go    = stop_edge;
  assign start_go   = start_edge & ~stop_edge;

  assign in_ok = (HCin <= 8'h23) && (HCin[3:0] <= 4'd9) &&
                 (MCin[7:4] <= 4'd5) && (MCin[3:0] <= 4'd9) &&
                 (SCin[7:4] <= 4'd5) && (SCin[3:0] <= 4'd9);
  assign in_nz = |{HCin, MCin, SCin};

  assign dec_val = bcd_dec({HCout, MCout, SCout});
  assign edit_en = mode_en && (st == EDIT);
  assign state   = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= EDIT;
      HCout     <= 8'h00;
      MCout     <= 8'h00;
      SCout     <= 8'h00;
      alarm     <= 1'b0;
      start_ref <= 1'b0;
      stop_ref  <= 1'b0;
      alarm_cnt <= 8'd0;
    end else begin
      start_ref <= BTstart;
      stop_ref  <= BTstop;
      case (st)
        EDIT: begin
          if (start_go && in_ok && in_nz) begin
            HCout <= HCin;
            MCout <= MCin;
            SCout <= SCin;
            st    <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            if (dec_val == 24'h000000) begin
              {HCout, MCout, SCout} <= 24'h000000;
              alarm     <= 1'b1;
              alarm_cnt <= 8'd0;
              st        <= DONE;
            end else begin
              {HCout, MCout, SCout} <= dec_val;
              if (stop_go) st <= PAUSE;
            end
          end else if (stop_go) begin
            st <= PAUSE;
          end
        end
        PAUSE: begin
          if (stop_go) begin
            {HCout, MCout, SCout} <= 24'h000000;
            st <= EDIT;
          end else if (start_go) begin
            st <= RUN;
          end
        end
        DONE: begin
          if (start_go || stop_go) begin
            alarm     <= 1'b0;
            alarm_cnt <= 8'd0;
            st        <= EDIT;
          end else if (tick) begin
            if (alarm_cnt == ALARM_LIM - 8'd1) begin
              alarm     <= 1'b0;
              alarm_cnt <= 8'd0;
              st        <= EDIT;
            end else begin
              alarm_cnt <= alarm_cnt + 8'd1;
`ifdef CRONO_BLINK_EN
              alarm <= ~alarm;
`else
              alarm <= 1'b1;
`endif
            end
          end
        end
        default: st <= EDIT;
      endcase
    end
  end

endmodule

// File: tb/tb_crono_ctrl.sv
// Self-checking bench for crono_ctrl (default build): vector table for load/first-decrement plus
// hand sequences for countdown, pause, alarm timeout, button corner cases and async reset.
module tb_crono_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       mode_en = 1'b1;
  logic       BTstart = 1'b0;
  logic       BTstop = 1'b0;
  logic [7:0] HCin = 8'h00, MCin = 8'h00, SCin = 8'h00;
  logic       edit_en;
  logic [7:0] HCout, MCout, SCout;
  logic       alarm;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  crono_ctrl #(.ALARM_SECS(10)) dut (
    .clk(clk), .reset(reset), .tick(tick), .mode_en(mode_en),
    .BTstart(BTstart), .BTstop(BTstop),
    .HCin(HCin), .MCin(MCin), .SCin(SCin),
    .edit_en(edit_en), .HCout(HCout), .MCout(MCout), .SCout(SCout),
    .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hc, mc, sc;
    logic [1:0] st1;
    logic [7:0] h2, m2, s2;
    logic [1:0] st2;
    logic       al2;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic [7:0] h, m, s;
    logic       al;
  } exp_t;

  vec_t vecs [12];
  exp_t exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string n, input logic [1:0] s, input logic [7:0] h,
                          input logic [7:0] m, input logic [7:0] sec, input logic a);
    exp_t e;
    e.name = n; e.st = s; e.h = h; e.m = m; e.s = sec; e.al = a;
    exp_q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || HCout !== e.h || MCout !== e.m || SCout !== e.s || alarm !== e.al) begin
        failures++;
        $display("FAIL %s: got st=%0d %h:%h:%h al=%b, required st=%0d %h:%h:%h al=%b",
                 e.name, state, HCout, MCout, SCout, alarm, e.st, e.h, e.m, e.s, e.al);
      end
    end
  endtask

  task automatic check_bit(input string n, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %b, required %b", n, got, req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic press_start();
    BTstart = 1'b1; step(); BTstart = 1'b0; step();
  endtask

  task automatic press_stop();
    BTstop = 1'b1; step(); BTstop = 1'b0; step();
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  task automatic set_in(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    HCin = h; MCin = m; SCin = s;
  endtask

  initial begin
    vecs[0]  = '{8'h00, 8'h00, 8'h03, 2'd1, 8'h00, 8'h00, 8'h02, 2'd1, 1'b0};
    vecs[1]  = '{8'h01, 8'h00, 8'h00, 2'd1, 8'h00, 8'h59, 8'h59, 2'd1, 1'b0};
    vecs[2]  = '{8'h10, 8'h00, 8'h00, 2'd1, 8'h09, 8'h59, 8'h59, 2'd1, 1'b0};
    vecs[3]  = '{8'h23, 8'h59, 8'h59, 2'd1, 8'h23, 8'h59, 8'h58, 2'd1, 1'b0};
    vecs[4]  = '{8'h00, 8'h10, 8'h00, 2'd1, 8'h00, 8'h09, 8'h59, 2'd1, 1'b0};
    vecs[5]  = '{8'h00, 8'h00, 8'h01, 2'd1, 8'h00, 8'h00, 8'h00, 2'd3, 1'b1};
    vecs[6]  = '{8'h24, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[7]  = '{8'h00, 8'h60, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[8]  = '{8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[9]  = '{8'h1A, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[10] = '{8'h00, 8'h0A, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[11] = '{8'h00, 8'h00, 8'h5A, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0};

    #2;
    push_exp("reset_state", 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    check();
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      do_reset();
      set_in(vecs[i].hc, vecs[i].mc, vecs[i].sc);
      if (vecs[i].st1 == 2'd1)
        push_exp($sformatf("vec%0d_load", i), 2'd1, vecs[i].hc, vecs[i].mc, vecs[i].sc, 1'b0);
      else
        push_exp($sformatf("vec%0d_load", i), 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
      press_start();
      check();
      push_exp($sformatf("vec%0d_tick", i), vecs[i].st2, vecs[i].h2, vecs[i].m2, vecs[i].s2, vecs[i].al2);
      do_tick();
      check();
    end

    // full countdown into DONE, then alarm timeout
    do_reset();
    set_in(8'h00, 8'h00, 8'h03);
    push_exp("cd_load", 2'd1, 8'h00, 8'h00, 8'h03, 1'b0);
    press_start(); check();
    push_exp("cd_t1", 2'd1, 8'h00, 8'h00, 8'h02, 1'b0); do_tick(); check();
    push_exp("cd_t2", 2'd1, 8'h00, 8'h00, 8'h01, 1'b0); do_tick(); check();
    push_exp("cd_t3", 2'd3, 8'h00, 8'h00, 8'h00, 1'b1); do_tick(); check();
    check_bit("done_edit_en", edit_en, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      push_exp($sformatf("done_tick%0d", k), 2'd3, 8'h00, 8'h00, 8'h00, 1'b1);
      do_tick(); step(); check();
    end
    push_exp("done_tick10", 2'd0, 8'h00, 8'h00, 8'h00, 1'b0); do_tick(); check();
    check_bit("edit_en_back", edit_en, 1'b1);

    // pause / resume / cancel
    do_reset();
    set_in(8'h00, 8'h00, 8'h10);
    push_exp("pz_load", 2'd1, 8'h00, 8'h00, 8'h10, 1'b0); press_start(); check();
    push_exp("pz_stop", 2'd2, 8'h00, 8'h00, 8'h10, 1'b0); press_stop(); check();
    push_exp("pz_tick1", 2'd2, 8'h00, 8'h00, 8'h10, 1'b0); do_tick(); check();
    push_exp("pz_tick2", 2'd2, 8'h00, 8'h00, 8'h10, 1'b0); do_tick(); check();
    push_exp("pz_resume", 2'd1, 8'h00, 8'h00, 8'h10, 1'b0); press_start(); check();
    push_exp("pz_run_tick", 2'd1, 8'h00, 8'h00, 8'h09, 1'b0); do_tick(); check();
    push_exp("pz_stop2", 2'd2, 8'h00, 8'h00, 8'h09, 1'b0); press_stop(); check();
    push_exp("pz_cancel", 2'd0, 8'h00, 8'h00, 8'h00, 1'b0); press_stop(); check();

    // acknowledge alarm early
    do_reset();
    set_in(8'h00, 8'h00, 8'h01);
    push_exp("ack_load", 2'd1, 8'h00, 8'h00, 8'h01, 1'b0); press_start(); check();
    push_exp("ack_done", 2'd3, 8'h00, 8'h00, 8'h00, 1'b1); do_tick(); check();
    do_tick(); step(); do_tick();
    push_exp("ack_2ticks", 2'd3, 8'h00, 8'h00, 8'h00, 1'b1); check();
    push_exp("ack_stop", 2'd0, 8'h00, 8'h00, 8'h00, 1'b0); press_stop(); check();

    // start and stop in the same cycle in EDIT
    do_reset();
    set_in(8'h00, 8'h00, 8'h05);
    BTstart = 1'b1; BTstop = 1'b1; step(); BTstart = 1'b0; BTstop = 1'b0; step();
    push_exp("both_edges", 2'd0, 8'h00, 8'h00, 8'h00, 1'b0); check();

    // mode_en low discards edges; held button after re-enable gives none
    mode_en = 1'b0; step();
    check_bit("edit_en_mode_off", edit_en, 1'b0);
    press_start();
    push_exp("mode_off_start", 2'd0, 8'h00, 8'h00, 8'h00, 1'b0); check();
    BTstart = 1'b1; step(); mode_en = 1'b1; step();
    push_exp("held_after_enable", 2'd0, 8'h00, 8'h00, 8'h00, 1'b0); check();
    BTstart = 1'b0; step();

    // tick and stop together in RUN
    push_exp("ts_load", 2'd1, 8'h00, 8'h00, 8'h05, 1'b0); press_start(); check();
    tick = 1'b1; BTstop = 1'b1; step(); tick = 1'b0; BTstop = 1'b0;
    push_exp("ts_pause", 2'd2, 8'h00, 8'h00, 8'h04, 1'b0); check();
    step();
    push_exp("ts_resume", 2'd1, 8'h00, 8'h00, 8'h04, 1'b0); press_start(); check();
    do_tick(); do_tick(); do_tick();
    push_exp("ts_at_one", 2'd1, 8'h00, 8'h00, 8'h01, 1'b0); check();
    tick = 1'b1; BTstop = 1'b1; step(); tick = 1'b0; BTstop = 1'b0;
    push_exp("ts_done_wins", 2'd3, 8'h00, 8'h00, 8'h00, 1'b1); check();
    step();

    // async reset mid-RUN
    do_reset();
    set_in(8'h00, 8'h00, 8'h05);
    press_start();
    do_tick();
    push_exp("rst_pre", 2'd1, 8'h00, 8'h00, 8'h04, 1'b0); check();
    reset = 1'b0;
    #2;
    push_exp("rst_async", 2'd0, 8'h00, 8'h00, 8'h00, 1'b0); check();
    reset = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
